// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register write countdowns plus writeback-slot reservations producing RAW/WAW/structural stalls.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_waddr,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                src1_re,
    input  logic [ADDR_W-1:0]   src1_addr,
    input  logic                src2_re,
    input  logic [ADDR_W-1:0]   src2_addr,
    output logic                stall_o,
    output logic                raw_stall_o,
    output logic                waw_stall_o,
    output logic                struct_stall_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [MAX_LAT-1:0]  wb_busy_o
);
    logic [LAT_W-1:0]   cnt_q [NUM_REGS];
    logic [LAT_W-1:0]   cnt_d [NUM_REGS];
    logic [MAX_LAT-1:0] wb_q, wb_d, wb_sh;
    logic [LAT_W-1:0]   eff_lat, lat_m1;
    logic               dst_wr, write_issue;

    always_comb begin
        eff_lat = issue_lat == '0 ? LAT_W'(1)
                : issue_lat > LAT_W'(MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
        lat_m1 = eff_lat - LAT_W'(1);
        wb_sh = wb_q >> lat_m1;
        dst_wr = issue_valid & issue_we & (issue_waddr != '0);
        raw_stall_o = ~rst & issue_valid &
                      ((src1_re & (src1_addr != '0) & (cnt_q[src1_addr] != '0)) |
                       (src2_re & (src2_addr != '0) & (cnt_q[src2_addr] != '0)));
        waw_stall_o = ~rst & dst_wr & (cnt_q[issue_waddr] > lat_m1);
        struct_stall_o = ~rst & dst_wr & wb_sh[0];
        stall_o = raw_stall_o | waw_stall_o | struct_stall_o;
        write_issue = dst_wr & ~stall_o;
    end

    // The new write overrides the decrement of its own destination counter.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            cnt_d[r] = cnt_q[r] != '0 ? cnt_q[r] - LAT_W'(1) : '0;
        if (write_issue)
            cnt_d[issue_waddr] = lat_m1;
        cnt_d[0] = '0;
        wb_d = (wb_q >> 1) |
               ((write_issue && lat_m1 != '0) ? MAX_LAT'(1) << (lat_m1 - LAT_W'(1)) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
        end else begin
            wb_q <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            pending_o[r] = (r != 0) && (cnt_q[r] != '0);
        wb_busy_o = wb_q;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random issue streams checked against an absolute-cycle model of result completion.
module tb_hazard_scoreboard;
    localparam int NR = 32, AW = 5, ML = 4, LW = 3;

    logic clk = 0;
    always #5 clk = ~clk;

    logic          rst = 1, issue_valid = 0, issue_we = 0, src1_re = 0, src2_re = 0;
    logic [AW-1:0] issue_waddr = 0, src1_addr = 0, src2_addr = 0;
    logic [LW-1:0] issue_lat = 0;
    logic          stall_o, raw_stall_o, waw_stall_o, struct_stall_o;
    logic [NR-1:0] pending_o;
    logic [ML-1:0] wb_busy_o;

    hazard_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .MAX_LAT(ML), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_waddr(issue_waddr), .issue_lat(issue_lat),
        .src1_re(src1_re), .src1_addr(src1_addr), .src2_re(src2_re), .src2_addr(src2_addr),
        .stall_o(stall_o), .raw_stall_o(raw_stall_o), .waw_stall_o(waw_stall_o),
        .struct_stall_o(struct_stall_o), .pending_o(pending_o), .wb_busy_o(wb_busy_o)
    );

    // Model: absolute cycle at which each register's result becomes readable,
    // and the set of absolute cycles whose writeback slot is claimed.
    int ready_at [NR];
    bit reserved [int];
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    logic          s_stall, s_raw, s_waw, s_struct;
    logic [NR-1:0] s_pend;
    logic [ML-1:0] s_wb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int lat);
        return lat == 0 ? 1 : (lat > ML ? ML : lat);
    endfunction

    task automatic step(input bit v, input bit we, input int wa, input int lat,
                        input bit r1e, input int r1a, input bit r2e, input int r2a, input bit rs);
        int l;
        bit e_raw, e_waw, e_st, e_stall;
        logic [NR-1:0] e_pend;
        logic [ML-1:0] e_wb;
        rst = rs; issue_valid = v; issue_we = we; issue_waddr = AW'(wa); issue_lat = LW'(lat);
        src1_re = r1e; src1_addr = AW'(r1a); src2_re = r2e; src2_addr = AW'(r2a);
        @(negedge clk);
        l = eff(lat);
        e_raw = !rs && v && ((r1e && r1a != 0 && ready_at[r1a] > cyc) ||
                             (r2e && r2a != 0 && ready_at[r2a] > cyc));
        e_waw = !rs && v && we && wa != 0 && ready_at[wa] >= cyc + l;
        e_st  = !rs && v && we && wa != 0 && reserved.exists(cyc + l);
        e_stall = e_raw || e_waw || e_st;
        for (int r = 0; r < NR; r++) e_pend[r] = r != 0 && ready_at[r] > cyc;
        for (int j = 0; j < ML; j++) e_wb[j] = reserved.exists(cyc + j + 1);
        s_stall = stall_o; s_raw = raw_stall_o; s_waw = waw_stall_o; s_struct = struct_stall_o;
        s_pend = pending_o; s_wb = wb_busy_o;
        chk("raw_stall", 32'(s_raw), 32'(e_raw));
        chk("waw_stall", 32'(s_waw), 32'(e_waw));
        chk("struct_stall", 32'(s_struct), 32'(e_st));
        chk("stall", 32'(s_stall), 32'(e_stall));
        chk("pending", s_pend, e_pend);
        chk("wb_busy", 32'(s_wb), 32'(e_wb));
        @(posedge clk);
        if (rs) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            reserved.delete();
        end else if (v && !e_stall && we && wa != 0) begin
            ready_at[wa] = cyc + l;
            if (l >= 2) reserved[cyc + l] = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input int wa, input int lat);
        step(1, 1, wa, lat, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(1, 0, 0, 0, 1, a, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 4, 3, 1, 4, 0, 0, 1);
        chk("lit_rst_stall", 32'(s_stall), 0);
        chk("lit_rst_pend", s_pend, 0);
        idle(1);
        chk("lit_rst_wb", 32'(s_wb), 0);
        // RAW
        issue(5, 3); rd(5);
        chk("lit_raw_c1", 32'(s_raw), 1);
        rd(5);
        chk("lit_raw_c2", 32'(s_raw), 1);
        rd(5);
        chk("lit_raw_c3", 32'(s_stall), 0);
        chk("lit_raw_pend5", 32'(s_pend[5]), 0);
        idle(5);
        // back-to-back forwarding
        issue(7, 1); rd(7);
        chk("lit_b2b_stall", 32'(s_stall), 0);
        chk("lit_b2b_pend", s_pend, 0);
        idle(5);
        // WAW
        issue(3, 4); issue(3, 2);
        chk("lit_waw_c1", 32'(s_waw), 1);
        issue(3, 2);
        chk("lit_waw_c2", 32'(s_waw), 1);
        issue(3, 2);
        chk("lit_waw_c3", 32'(s_stall), 0);
        idle(5);
        // structural
        issue(1, 3); issue(2, 2);
        chk("lit_struct_c1", 32'(s_struct), 1);
        issue(2, 2);
        chk("lit_struct_c2", 32'(s_stall), 0);
        idle(5);
        // clamping and r0
        issue(4, 0); idle(1);
        chk("lit_lat0_pend", s_pend, 0);
        issue(6, 7); idle(1);
        chk("lit_lat7_pend", s_pend, 32'h40);
        chk("lit_lat7_wb", 32'(s_wb), 32'h4);
        idle(5);
        issue(0, 4); idle(1);
        chk("lit_r0_pend", s_pend, 0);
        chk("lit_r0_wb", 32'(s_wb), 0);
        // self dependency
        step(1, 1, 5, 3, 1, 5, 0, 0, 0);
        chk("lit_self_stall", 32'(s_stall), 0);
        rd(5);
        chk("lit_self_next_raw", 32'(s_raw), 1);
        idle(5);
        // reset mid-operation
        issue(9, 4);
        step(1, 0, 0, 0, 1, 9, 0, 0, 1);
        chk("lit_midrst_stall", 32'(s_stall), 0);
        rd(9);
        chk("lit_midrst_raw", 32'(s_raw), 0);
        chk("lit_midrst_pend", s_pend, 0);
        chk("lit_midrst_wb", 32'(s_wb), 0);
        // random traffic over a few registers to provoke collisions
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 59) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
